// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the result record used by the writeback unit.
package wb_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_result_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of load results with occupancy count.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  wb_result_t               din,
    output wb_result_t               dout,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    wb_result_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign count = wr_ptr - rd_ptr;
    assign full = count == (AW+1)'(DEPTH);
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clock)
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and buffered load results into one registered regfile write port
// and tracks pending destinations. Define WB_BYPASS_EN to add same-cycle forwarding outputs.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int LSU_FIFO_DEPTH = 4,
    parameter int LSU_STARVE_MAX = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_stall,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  w_en,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       w_data,
    output logic                  err_waw
`ifdef WB_BYPASS_EN
   ,output logic [XLEN-1:0]       rs1_fwd_data,
    output logic [XLEN-1:0]       rs2_fwd_data
`endif
);
    localparam int CW = $clog2(LSU_STARVE_MAX + 1);
    wb_result_t head, sel;
    logic full, has_head, alu_win, pop, push, lose, sel_valid;
    logic [$clog2(LSU_FIFO_DEPTH):0] count;
    logic [CW-1:0] cnt, cnt_n;
    logic [NUM_REGS-1:0] sb, sb_set, sb_clr;

    wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
        .clock(clock), .reset_n(reset_n), .push(push), .pop(pop),
        .din('{rd: lsu_rd, data: lsu_data}), .dout(head), .full(full), .count(count)
    );

    assign lsu_ready = !full;
    assign push = lsu_valid && !full;
    assign has_head = count != '0;
    assign alu_win = alu_valid && !alu_stall;
    assign pop = has_head && !alu_win;
    assign lose = has_head && alu_win;
    assign sel_valid = alu_win || pop;

    always_comb begin
        sel = alu_win ? '{rd: alu_rd, data: alu_data} : head;
        cnt_n = pop ? '0 : lose ? cnt + 1'b1 : cnt;
        sb_set = (issue_valid && issue_rd != '0) ? NUM_REGS'(1) << issue_rd : '0;
        sb_clr = w_en ? NUM_REGS'(1) << rd_addr : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_en <= 1'b0;
            rd_addr <= '0;
            w_data <= '0;
            alu_stall <= 1'b0;
            cnt <= '0;
            sb <= '0;
            err_waw <= 1'b0;
        end else begin
            w_en <= sel_valid && sel.rd != '0;
            if (sel_valid) begin
                rd_addr <= sel.rd;
                w_data <= sel.data;
            end
            cnt <= cnt_n;
            // A stalled cycle always pops, so the stall lasts exactly one cycle.
            alu_stall <= cnt_n == CW'(LSU_STARVE_MAX);
            sb <= (sb & ~sb_clr) | sb_set;
            if (issue_valid && issue_rd != '0 && sb[issue_rd]) err_waw <= 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    logic fwd1, fwd2;
    always_comb begin
        fwd1 = w_en && rd_addr == rs1_addr;
        fwd2 = w_en && rd_addr == rs2_addr;
        rs1_busy = sb[rs1_addr] && !fwd1;
        rs2_busy = sb[rs2_addr] && !fwd2;
        rs1_fwd_data = fwd1 ? w_data : '0;
        rs2_fwd_data = fwd2 ? w_data : '0;
    end
`else
    assign rs1_busy = sb[rs1_addr];
    assign rs2_busy = sb[rs2_addr];
`endif
endmodule
